sr_chain_writer: RTL and testbench
==================================

Name: sr_chain_writer

Overview:
- Serialises parallel words into a chain of 74HC595-style shift registers: drives the serial data line, the shift clock (SH_CP) and the storage/latch clock (ST_CP).
- Successor to the fixed 24-bit display writer. Adds parametrised word width, shift-clock divider and bit order.
- Adds a valid/ready handshake with a one-word holding buffer, so frames go out back-to-back.
- Sits between the clock/display formatting logic and the board pins.

Parameters:
- DATA_W, 24, word width = total bits in the register chain (>=1).
- CLK_DIV, 4, i_CLK cycles per SH_CP/ST_CP half-phase (>=1).
- MSB_FIRST, 1, 1: bit DATA_W-1 is shifted first; 0: bit 0 is shifted first.

Ports:
- i_CLK  in  1  system clock; all logic on its rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_DATA  in  DATA_W  word to display.
- i_VALID  in  1  i_DATA valid; accepted on an edge where i_VALID && o_READY.
- o_READY  out  1  holding buffer empty; can accept a word.
- o_BUSY  out  1  a frame is in progress.
- o_DONE  out  1  one-cycle pulse in the final cycle of each frame.
- o_SH_CP  out  1  shift clock to the chain.
- o_ST_CP  out  1  latch clock to the chain.
- o_DATA  out  1  serial data to the chain.

Behaviour:
- Reset (i_RST=1 at an edge):
  - All outputs go to 0, including o_READY. Buffer is emptied. FSM goes to IDLE.
  - o_READY becomes 1 on the first edge with i_RST=0.
  - Reset mid-frame aborts the frame with no latch pulse: ST_CP stays 0.
- FSM states: IDLE, SH_LO, SH_HI, LATCH, GAP. Each non-IDLE state lasts exactly CLK_DIV cycles, timed by the phase counter.
- Accept from IDLE:
  - On edge E0 the word loads directly into the shifter; the buffer stays empty; FSM goes to SH_LO.
  - Period k means the k-th clock period after E0.
- Bit transfer, bit index i = 0..DATA_W-1 in send order:
  - SH_LO occupies periods [2*CLK_DIV*i, 2*CLK_DIV*i + CLK_DIV): o_SH_CP=0.
  - SH_HI occupies the next CLK_DIV periods: o_SH_CP=1.
  - o_DATA holds bit i, stable for all 2*CLK_DIV periods, so it is valid across the SH_CP rising edge.
- LATCH: periods [2*DATA_W*CLK_DIV, +CLK_DIV): o_ST_CP=1, o_SH_CP=0, o_DATA=0.
- GAP: next CLK_DIV periods, all pin outputs 0. o_DONE=1 in the last GAP period only.
- Frame length is (2*DATA_W+2)*CLK_DIV cycles. o_BUSY=1 for exactly those periods.
- While busy:
  - If o_READY=1 and i_VALID=1, the word goes into the buffer and o_READY drops on the next edge.
  - At the end of GAP with the buffer full, the buffer moves into the shifter and the next frame's period 0 starts immediately (no IDLE cycle).
  - o_READY returns to 1 on the following edge.
- Word arriving in the last GAP cycle with the buffer empty: it is written to the buffer, then starts after that GAP with no extra delay beyond that one cycle.
- Buffer full: i_VALID is ignored; words are never overwritten.
- o_READY is registered; it is never combinationally dependent on i_VALID.
- The input word is captured at acceptance; later changes on i_DATA have no effect.
- CLK_DIV=1: SH_CP toggles every cycle (half the i_CLK rate). All rules above still hold.

Decomposition:
- Package sr_chain_writer_pkg: state enum (IDLE, SH_LO, SH_HI, LATCH, GAP); width helper constants, including the phase-counter width $clog2(CLK_DIV) with a floor of 1 bit.
- Sub-module sr_phase_div:
  - Counts 0..CLK_DIV-1 and asserts o_PHASE_END on the last count.
  - Restarts on a load strobe.
  - Synchronous active-high reset.
- Bit counter, buffer and FSM stay in the top level.

Test Plan:
- DATA_W=8, CLK_DIV=2, MSB_FIRST=1, send 0xA5 from idle:
  - o_DATA sampled at the 8 o_SH_CP rising edges = 1,0,1,0,0,1,0,1.
  - o_ST_CP=1 in periods 32-33; o_DONE in period 35.
  - o_BUSY for exactly 36 cycles.
- Same configuration with MSB_FIRST=0, send 0xA5: sampled bits = 1,0,1,0,0,1,0,1 in LSB order (0xA5 is a palindrome, so also send 0x01 and check sampled bits 1,0,0,0,0,0,0,0).
- Back-to-back: send 0x3C, then 0xC3 at period 5:
  - o_READY low from period 6 until the edge after the first frame ends.
  - Second frame starts exactly at period 36; o_BUSY never drops in between.
- Buffer full: with a frame in flight and the buffer holding 0x11, drive 0x22 with i_VALID=1 for 10 cycles. Only 0x3C-frame then 0x11 are shifted; 0x22 never appears.
- Reset at period 20 of a frame: next edge all outputs 0 with no ST_CP pulse; o_READY=1 one cycle after reset is released; a fresh 0xFF frame completes normally.
- Default parameters (DATA_W=24, CLK_DIV=4), 50 random words with random i_VALID gaps:
  - Scoreboard compares the reconstructed chain contents at each ST_CP rising edge to the accepted words, in order.
  - Every frame lasts 200 cycles.

Source files
------------

// File: rtl/sr_chain_writer_pkg.sv
// sr_chain_writer_pkg: state encoding and width helpers shared by
// the shift-register chain writer and its phase divider.
package sr_chain_writer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SH_LO,
    SH_HI,
    LATCH,
    GAP
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int w_floor1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_phase_div.sv
// sr_phase_div: counts 0..CLK_DIV-1, o_PHASE_END on the last count,
// o_PRE_END one count earlier; i_LOAD and i_RST restart at 0.
module sr_phase_div
  import sr_chain_writer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_LOAD,
  output logic o_PHASE_END,
  output logic o_PRE_END
);

  localparam int CW = w_floor1(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE =
    CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_CLK) begin
    if (i_RST || i_LOAD || o_PHASE_END)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign o_PHASE_END = (cnt == LAST);

  // With a single-cycle phase every count is the last one.
  assign o_PRE_END = (CLK_DIV == 1) ? 1'b1 : (cnt == PRE);

endmodule

// File: rtl/sr_chain_writer.sv
// sr_chain_writer: serialises DATA_W-bit words into a 595-style chain.
// Ports: i_CLK/i_RST, i_DATA/i_VALID/o_READY, o_BUSY/o_DONE, pin outputs.
module sr_chain_writer
  import sr_chain_writer_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_VALID,
  output logic              o_READY,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_SH_CP,
  output logic              o_ST_CP,
  output logic              o_DATA
);

  localparam int BW = w_floor1(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full;
  logic [BW-1:0]     bit_idx;
  logic              phase_end;
  logic              pre_end;
  logic              accept;
  logic              start;
  logic              done_nxt;

  sr_phase_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_LOAD     (state == IDLE),
    .o_PHASE_END(phase_end),
    .o_PRE_END  (pre_end)
  );

  function automatic logic [DATA_W-1:0] shift1(
    input logic [DATA_W-1:0] v
  );
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign accept = i_VALID && o_READY;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (buf_full || accept) state_nxt = SH_LO;
      SH_LO: if (phase_end) state_nxt = SH_HI;
      SH_HI:
        if (phase_end)
          state_nxt = (bit_idx == LAST_BIT) ? LATCH : SH_LO;
      LATCH: if (phase_end) state_nxt = GAP;
      GAP:
        if (phase_end)
          state_nxt = buf_full ? SH_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A frame starts from IDLE or straight out of GAP when the
  // buffer already holds the next word.
  assign start = (state_nxt == SH_LO) &&
                 ((state == IDLE) || (state == GAP));

  // DONE is registered, so it is raised one cycle before the last
  // GAP count; after a wrap that only happens for single-cycle phases.
  assign done_nxt = (state_nxt == GAP) &&
                    (phase_end ? (CLK_DIV == 1) : pre_end);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= IDLE;
      shreg    <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      bit_idx  <= '0;
      o_READY  <= 1'b0;
      o_BUSY   <= 1'b0;
      o_DONE   <= 1'b0;
      o_SH_CP  <= 1'b0;
      o_ST_CP  <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_BUSY  <= (state_nxt != IDLE);
      o_SH_CP <= (state_nxt == SH_HI);
      o_ST_CP <= (state_nxt == LATCH);
      o_DONE  <= done_nxt;

      // Zeros shift in behind the word, so after the last bit
      // the shifter is empty and the data pin idles low.
      if (start) begin
        shreg   <= buf_full ? buf_q : i_DATA;
        bit_idx <= '0;
      end else if ((state == SH_HI) && phase_end) begin
        shreg <= shift1(shreg);
        if (bit_idx != LAST_BIT)
          bit_idx <= bit_idx + 1'b1;
      end

      if (start && buf_full) begin
        buf_full <= 1'b0;
        o_READY  <= 1'b1;
      end else if (accept && (state != IDLE)) begin
        buf_q    <= i_DATA;
        buf_full <= 1'b1;
        o_READY  <= 1'b0;
      end else begin
        o_READY  <= !buf_full;
      end
    end
  end

  assign o_DATA = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];

endmodule

// File: tb/tb_sr_chain_writer.sv
// tb_sr_chain_writer: directed and scoreboard tests for the
// shift-register chain writer in three configurations.
module tb_sr_chain_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int n_tests = 0;
  int n_fail = 0;

  logic       a_valid, a_ready, a_busy, a_done, a_sh, a_st, a_sd;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_busy, b_done, b_sh, b_st, b_sd;
  logic [7:0] b_data;
  logic        c_valid, c_ready, c_busy, c_done, c_sh, c_st, c_sd;
  logic [23:0] c_data;

  sr_chain_writer #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) u_a (
    .i_CLK(clk), .i_RST(rst), .i_DATA(a_data), .i_VALID(a_valid),
    .o_READY(a_ready), .o_BUSY(a_busy), .o_DONE(a_done),
    .o_SH_CP(a_sh), .o_ST_CP(a_st), .o_DATA(a_sd));

  sr_chain_writer #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(0)) u_b (
    .i_CLK(clk), .i_RST(rst), .i_DATA(b_data), .i_VALID(b_valid),
    .o_READY(b_ready), .o_BUSY(b_busy), .o_DONE(b_done),
    .o_SH_CP(b_sh), .o_ST_CP(b_st), .o_DATA(b_sd));

  sr_chain_writer u_c (
    .i_CLK(clk), .i_RST(rst), .i_DATA(c_data), .i_VALID(c_valid),
    .o_READY(c_ready), .o_BUSY(c_busy), .o_DONE(c_done),
    .o_SH_CP(c_sh), .o_ST_CP(c_st), .o_DATA(c_sd));

  // Trace capture for the 8-bit instances (A or B).
  logic sel_b;
  logic m_ready, m_busy, m_done, m_sh, m_st, m_sd;
  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_sh    = sel_b ? b_sh    : a_sh;
  assign m_st    = sel_b ? b_st    : a_st;
  assign m_sd    = sel_b ? b_sd    : a_sd;

  logic [127:0] tr_sh, tr_st, tr_sd, tr_busy, tr_done, tr_ready;

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // SH_CP high periods of an 8-bit, CLK_DIV=2 frame starting at base.
  function automatic logic [127:0] shpat(input int base);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m |= span(base + 4*i + 2, base + 4*i + 3);
    return m;
  endfunction

  // Data bits seen at SH_CP rising edges; first bit ends at the MSB.
  function automatic void extract(input int from, input int to,
                                  output logic [15:0] bits,
                                  output int n);
    bits = '0;
    n = 0;
    for (int k = from; k < to; k++)
      if (k > 0 && tr_sh[k] && !tr_sh[k-1]) begin
        bits = {bits[14:0], tr_sd[k]};
        n++;
      end
  endfunction

  task automatic kick(input logic [7:0] d);
    @(negedge clk);
    n_tests++;
    if (m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_ready: got %b want 1", m_ready);
    end
    if (sel_b) begin b_valid = 1'b1; b_data = d; end
    else begin a_valid = 1'b1; a_data = d; end
  endtask

  // Period k = k-th negedge after the accepting edge; valid driven
  // in period k is seen by the edge that ends period k.
  task automatic run(input int n,
                     input int v1_at, input int v1_len, input logic [7:0] v1_d,
                     input int v2_at, input int v2_len, input logic [7:0] v2_d);
    logic       drv;
    logic [7:0] dd;
    tr_sh = '0; tr_st = '0; tr_sd = '0;
    tr_busy = '0; tr_done = '0; tr_ready = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr_sh[k] = m_sh;     tr_st[k] = m_st;     tr_sd[k] = m_sd;
      tr_busy[k] = m_busy; tr_done[k] = m_done; tr_ready[k] = m_ready;
      drv = 1'b0;
      dd = 8'($urandom);
      if (k >= v1_at && k < v1_at + v1_len) begin drv = 1'b1; dd = v1_d; end
      if (k >= v2_at && k < v2_at + v2_len) begin drv = 1'b1; dd = v2_d; end
      if (sel_b) begin b_valid = drv; b_data = dd; end
      else begin a_valid = drv; a_data = dd; end
    end
  endtask

  task automatic test_reset();
    logic [17:0] o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = {a_ready, a_busy, a_done, a_sh, a_st, a_sd,
         b_ready, b_busy, b_done, b_sh, b_st, b_sd,
         c_ready, c_busy, c_done, c_sh, c_st, c_sd};
    n_tests++;
    if (o !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 00000", o);
    end
    rst = 1'b0;
    @(negedge clk);
    o = '0;
    o[5:0] = {a_ready, b_ready, c_ready, a_busy, b_busy, c_busy};
    n_tests++;
    if (o[5:0] !== 6'b111000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 111000", o[5:0]);
    end
  endtask

  task automatic test_msb_first();
    logic [127:0] want;
    logic [15:0] bits;
    int nb;
    sel_b = 1'b0;
    kick(8'hA5);
    run(40, -1, 0, 8'h00, -1, 0, 8'h00);
    extract(0, 40, bits, nb);
    n_tests++;
    if (nb != 8 || bits[7:0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL msb_bits: got %0d edges %h want 8 edges a5", nb, bits[7:0]);
    end
    want = shpat(0);
    n_tests++;
    if (tr_sh[39:0] !== want[39:0]) begin
      n_fail++;
      $display("FAIL msb_shcp: got %h want %h", tr_sh[39:0], want[39:0]);
    end
    want = span(32, 33);
    n_tests++;
    if (tr_st[39:0] !== want[39:0]) begin
      n_fail++;
      $display("FAIL msb_stcp: got %h want %h", tr_st[39:0], want[39:0]);
    end
    want = span(35, 35);
    n_tests++;
    if (tr_done[39:0] !== want[39:0]) begin
      n_fail++;
      $display("FAIL msb_done: got %h want %h", tr_done[39:0], want[39:0]);
    end
    want = span(0, 35);
    n_tests++;
    if (tr_busy[39:0] !== want[39:0]) begin
      n_fail++;
      $display("FAIL msb_busy: got %h want %h", tr_busy[39:0], want[39:0]);
    end
    n_tests++;
    if (tr_sd[39:32] !== 8'h00 || tr_ready[39:0] !== 40'hff_ffff_ffff) begin
      n_fail++;
      $display("FAIL msb_idle_pins: data %h ready %h want 00 ffffffffff",
               tr_sd[39:32], tr_ready[39:0]);
    end
  endtask

  task automatic test_lsb_first();
    logic [127:0] want;
    logic [15:0] bits;
    int nb;
    sel_b = 1'b1;
    kick(8'hA5);
    run(40, -1, 0, 8'h00, -1, 0, 8'h00);
    extract(0, 40, bits, nb);
    n_tests++;
    if (nb != 8 || bits[7:0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL lsb_a5: got %0d edges %h want 8 edges a5", nb, bits[7:0]);
    end
    kick(8'h01);
    run(40, -1, 0, 8'h00, -1, 0, 8'h00);
    extract(0, 40, bits, nb);
    n_tests++;
    if (nb != 8 || bits[7:0] !== 8'h80) begin
      n_fail++;
      $display("FAIL lsb_01: got %0d edges %h want 8 edges 80", nb, bits[7:0]);
    end
    want = span(32, 33);
    n_tests++;
    if (tr_st[39:0] !== want[39:0] || tr_busy[39:0] !== 40'h0f_ffff_ffff) begin
      n_fail++;
      $display("FAIL lsb_frame: st %h busy %h want %h 0fffffffff",
               tr_st[39:0], tr_busy[39:0], want[39:0]);
    end
    sel_b = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] want;
    logic [15:0] bits;
    int nb;
    sel_b = 1'b0;
    kick(8'h3C);
    run(80, 5, 1, 8'hC3, -1, 0, 8'h00);
    extract(0, 80, bits, nb);
    n_tests++;
    if (nb != 16 || bits !== 16'h3CC3) begin
      n_fail++;
      $display("FAIL b2b_bits: got %0d edges %h want 16 edges 3cc3", nb, bits);
    end
    want = ~span(6, 35);
    n_tests++;
    if (tr_ready[40:0] !== want[40:0]) begin
      n_fail++;
      $display("FAIL b2b_ready: got %h want %h", tr_ready[40:0], want[40:0]);
    end
    want = span(0, 71);
    n_tests++;
    if (tr_busy[79:0] !== want[79:0]) begin
      n_fail++;
      $display("FAIL b2b_busy: got %h want %h", tr_busy[79:0], want[79:0]);
    end
    want = shpat(0) | shpat(36);
    n_tests++;
    if (tr_sh[79:0] !== want[79:0]) begin
      n_fail++;
      $display("FAIL b2b_shcp: got %h want %h", tr_sh[79:0], want[79:0]);
    end
    want = span(32, 33) | span(68, 69);
    n_tests++;
    if (tr_st[79:0] !== want[79:0]) begin
      n_fail++;
      $display("FAIL b2b_stcp: got %h want %h", tr_st[79:0], want[79:0]);
    end
    want = span(35, 35) | span(71, 71);
    n_tests++;
    if (tr_done[79:0] !== want[79:0]) begin
      n_fail++;
      $display("FAIL b2b_done: got %h want %h", tr_done[79:0], want[79:0]);
    end
  endtask

  task automatic test_buffer_full();
    logic [127:0] want;
    logic [15:0] bits;
    int nb;
    sel_b = 1'b0;
    kick(8'h3C);
    run(80, 3, 1, 8'h11, 10, 10, 8'h22);
    extract(0, 80, bits, nb);
    n_tests++;
    if (nb != 16 || bits !== 16'h3C11) begin
      n_fail++;
      $display("FAIL full_bits: got %0d edges %h want 16 edges 3c11", nb, bits);
    end
    want = ~span(4, 35);
    n_tests++;
    if (tr_ready[40:0] !== want[40:0]) begin
      n_fail++;
      $display("FAIL full_ready: got %h want %h", tr_ready[40:0], want[40:0]);
    end
    want = span(0, 71);
    n_tests++;
    if (tr_busy[79:0] !== want[79:0]) begin
      n_fail++;
      $display("FAIL full_busy: got %h want %h", tr_busy[79:0], want[79:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] want;
    logic [15:0] bits;
    logic [5:0] o;
    int nb;
    sel_b = 1'b0;
    kick(8'h3C);
    run(20, -1, 0, 8'h00, -1, 0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    o = {a_ready, a_busy, a_done, a_sh, a_st, a_sd};
    n_tests++;
    if (o !== 6'b0 || tr_st[19:0] !== 20'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b st %h want 000000 00000", o, tr_st[19:0]);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_st !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: ready %b busy %b st %b want 1 0 0",
               a_ready, a_busy, a_st);
    end
    kick(8'hFF);
    run(40, -1, 0, 8'h00, -1, 0, 8'h00);
    extract(0, 40, bits, nb);
    want = span(32, 33);
    n_tests++;
    if (nb != 8 || bits[7:0] !== 8'hFF || tr_st[39:0] !== want[39:0] ||
        tr_done[39:0] !== 40'h08_0000_0000) begin
      n_fail++;
      $display("FAIL rstmid_frame: %0d edges %h st %h done %h want 8 ff %h 0800000000",
               nb, bits[7:0], tr_st[39:0], tr_done[39:0], want[39:0]);
    end
  endtask

  // Scoreboard for the 24-bit instance: a 595 chain model latched on
  // ST_CP rising edges, compared with the accepted words in order.
  logic        mon_en = 1'b0;
  logic [23:0] chain = '0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  logic        c_sh_q = 1'b0, c_st_q = 1'b0, c_busy_q = 1'b0, c_done_q = 1'b0;
  int          cyc = 0, start_cyc = 0, n_latched = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (c_sh && !c_sh_q) chain = {chain[22:0], c_sd};
      if (c_st && !c_st_q) begin
        n_tests++;
        n_latched++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_latch: got %h want no frame", chain);
        end else begin
          exp_w = exp_q.pop_front();
          if (chain !== exp_w) begin
            n_fail++;
            $display("FAIL rand_latch: got %h want %h", chain, exp_w);
          end
        end
      end
      if (c_busy && (!c_busy_q || c_done_q)) start_cyc = cyc;
      if (c_done) begin
        n_tests++;
        if (cyc - start_cyc + 1 != 200) begin
          n_fail++;
          $display("FAIL rand_frame_len: got %0d want 200", cyc - start_cyc + 1);
        end
      end
    end
    c_sh_q = c_sh; c_st_q = c_st; c_busy_q = c_busy; c_done_q = c_done;
  end

  task automatic test_random();
    int waited;
    mon_en = 1'b1;
    for (int w = 0; w < 50; w++) begin
      c_valid = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      c_data = 24'($urandom);
      c_valid = 1'b1;
      waited = 0;
      while (c_ready !== 1'b1 && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_accept: ready %b after 1000 cycles want 1", c_ready);
        break;
      end
      exp_q.push_back(c_data);
      @(negedge clk);
      c_data = 24'($urandom);
    end
    c_valid = 1'b0;
    waited = 0;
    while ((c_busy !== 1'b0 || c_ready !== 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (n_latched != 50 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: latched %0d pending %0d want 50 0",
               n_latched, exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sel_b = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    c_valid = 1'b0; c_data = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_buffer_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
